// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer and its ALU.
package mul_seq_pkg;

  localparam int unsigned Width = 16;

  typedef enum logic [1:0] {
    MulIdle = 2'd0,
    MulRun  = 2'd1,
    MulFix  = 2'd2,
    MulDone = 2'd3
  } mul_state_e;

  typedef enum logic [2:0] {
    OpId  = 3'd0,
    OpAdd = 3'd1,
    OpSub = 3'd2,
    OpAnd = 3'd3,
    OpOr  = 3'd4,
    OpXor = 3'd5
  } alu_op_e;

  // 16-bit two's complement; 0x8000 maps to itself and is read as magnitude 32768.
  function automatic logic [Width-1:0] neg16(logic [Width-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Operand/product handshake bundle between the execute stage and the multiplier.
interface mul_seq_if;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [mul_seq_pkg::Width-1:0]         A;
  logic [mul_seq_pkg::Width-1:0]         B;
  logic                                  SIGNED;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [2*mul_seq_pkg::Width-1:0]       P;
  logic                                  busy;

  modport master (
    output in_valid, A, B, SIGNED, out_ready,
    input  in_ready, out_valid, P, busy
  );

  modport slave (
    input  in_valid, A, B, SIGNED, out_ready,
    output in_ready, out_valid, P, busy
  );

endinterface

// File: rtl/mul_seq_alu.sv
// 16-bit combinational ALU; the multiplier only uses OpAdd and OpId.
module mul_seq_alu
  import mul_seq_pkg::*;
(
  input  alu_op_e          op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             cin,
  output logic [Width-1:0] c,
  output logic             cout
);

  always_comb begin
    c    = a;
    cout = 1'b0;
    unique case (op)
      OpAdd:   {cout, c} = {1'b0, a} + {1'b0, b} + {{Width{1'b0}}, cin};
      OpSub:   {cout, c} = {1'b0, a} + {1'b0, ~b} + {{Width{1'b0}}, cin};
      OpAnd:   c = a & b;
      OpOr:    c = a | b;
      OpXor:   c = a ^ b;
      default: c = a;
    endcase
  end

endmodule

// File: rtl/mul_seq.sv
// Fixed-latency 16x16 multiplier: sign-magnitude pre-fix, 16 shift-add steps, post-fix.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic         clk,
  input logic         reset_n,
  mul_seq_if.slave    bus
);

  mul_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  alu_op_e            alu_op;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_c;
  logic               alu_cout;
  logic [2*WIDTH-1:0] prod;

  assign prod = {acc_q, mq_q};

  mul_seq_alu u_alu (
    .op   (alu_op),
    .a    (acc_q),
    .b    (alu_b),
    .cin  (1'b0),
    .c    (alu_c),
    .cout (alu_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    alu_op  = OpId;
    alu_b   = '0;
    case (state_q)
      MulIdle: begin
        if (bus.in_valid) begin
          sgn_d   = bus.SIGNED & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          mcand_d = (bus.SIGNED & bus.A[WIDTH-1]) ? neg16(bus.A) : bus.A;
          mq_d    = (bus.SIGNED & bus.B[WIDTH-1]) ? neg16(bus.B) : bus.B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MulRun;
        end
      end
      MulRun: begin
        alu_op = OpAdd;
        alu_b  = mq_q[0] ? mcand_q : '0;
        // Carry re-enters at the top as the 33-bit {cout, sum, mq} shifts right.
        {acc_d, mq_d} = {alu_cout, alu_c, mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = MulFix;
      end
      MulFix: begin
        p_d     = sgn_q ? (~prod + 1'b1) : prod;
        state_d = MulDone;
      end
      MulDone: begin
        if (bus.out_ready) state_d = MulIdle;
      end
      default: state_d = MulIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MulIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == MulIdle);
  assign bus.out_valid = (state_q == MulDone);
  assign bus.busy      = (state_q != MulIdle);
  assign bus.P         = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed vector table, handshake corners, random vs. model.
module tb_mul_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mul_seq_if mif ();

  mul_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Plain integer arithmetic on the operands read as signed or unsigned numbers.
  function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b, logic s);
    longint x, y;
    logic [63:0] r;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    r = x * y;
    return r[31:0];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (mif.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait in_ready", {31'b0, mif.in_ready}, 32'd1);
  endtask

  // Counts negedges after the accepting posedge until out_valid is seen.
  task automatic wait_valid(input bit drop_valid, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && drop_valid) mif.in_valid = 1'b0;
    end while (mif.out_valid !== 1'b1 && lat < 60);
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp, input bit full);
    int lat;
    wait_ready();
    mif.A         = a;
    mif.B         = b;
    mif.SIGNED    = s;
    mif.in_valid  = 1'b1;
    mif.out_ready = 1'b1;
    wait_valid(1'b1, lat);
    if (full) chk({name, " latency"}, 32'(lat), 32'd18);
    chk({name, " P"}, mif.P, exp);
    @(negedge clk);
    if (full) begin
      chk({name, " out_valid drop"}, {31'b0, mif.out_valid}, 32'd0);
      chk({name, " in_ready back"}, {31'b0, mif.in_ready}, 32'd1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic rs;

    vecs[0] = '{"u 3*5",         16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    vecs[1] = '{"u FFFF*FFFF",   16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[2] = '{"s -2*3",        16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA};
    vecs[3] = '{"s -1*-1",       16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[4] = '{"s 8000*8000",   16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[5] = '{"s 7FFF*8000",   16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vecs[6] = '{"u 0*ABCD",      16'h0000, 16'hABCD, 1'b0, 32'h00000000};
    vecs[7] = '{"u ABCD*1",      16'hABCD, 16'h0001, 1'b0, 32'h0000ABCD};

    mif.in_valid  = 1'b0;
    mif.A         = '0;
    mif.B         = '0;
    mif.SIGNED    = 1'b0;
    mif.out_ready = 1'b0;

    #12;
    chk("reset in_ready", {31'b0, mif.in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, mif.out_valid}, 32'd0);
    chk("reset busy", {31'b0, mif.busy}, 32'd0);
    chk("reset P", mif.P, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, 1'b1);

    // Backpressure, with a second request held pending while busy.
    wait_ready();
    mif.A = 16'd7; mif.B = 16'd9; mif.SIGNED = 1'b0;
    mif.in_valid = 1'b1; mif.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp busy", {31'b0, mif.busy}, 32'd1);
    chk("bp in_ready low", {31'b0, mif.in_ready}, 32'd0);
    mif.A = 16'h0011; mif.B = 16'h0011;
    wait_valid(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid held", {31'b0, mif.out_valid}, 32'd1);
      chk("bp P held", mif.P, 32'h0000003F);
      chk("bp no accept", {31'b0, mif.in_ready}, 32'd0);
      @(negedge clk);
    end
    mif.out_ready = 1'b1;
    @(negedge clk);
    chk("bp out_valid drop", {31'b0, mif.out_valid}, 32'd0);
    chk("bp in_ready after hs", {31'b0, mif.in_ready}, 32'd1);
    wait_valid(1'b1, lat);
    chk("bp second latency", 32'(lat), 32'd18);
    chk("bp second P", mif.P, 32'h00000121);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    wait_ready();
    mif.A = 16'h1234; mif.B = 16'h5678; mif.SIGNED = 1'b0; mif.in_valid = 1'b1;
    @(posedge clk);
    #1 mif.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst in_ready", {31'b0, mif.in_ready}, 32'd1);
    chk("midrst out_valid", {31'b0, mif.out_valid}, 32'd0);
    chk("midrst busy", {31'b0, mif.busy}, 32'd0);
    chk("midrst P", mif.P, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("after reset 2*2", 16'd2, 16'd2, 1'b0, 32'd4, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), ra, rb, rs, ref_mul(ra, rb, rs), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
